// File: rtl/sync_tx_pkg.sv
// rtl/sync_tx_pkg.sv - shared types and constants for the sync burst transmitter
// Purpose: FSM state encoding, {k,j} symbol codes and default burst geometry.
// Ports: none (package).
package sync_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Symbol codes as {k,j}
  localparam logic [1:0] SYM_K = 2'b10;
  localparam logic [1:0] SYM_J = 2'b01;

  localparam int DEF_SYNC_LEN = 8;
  localparam int DEF_GAP_LEN  = 2;
  localparam int DEF_CNT_W    = 4;

endpackage

// File: rtl/sync_tx_if.sv
// rtl/sync_tx_if.sv - request and symbol-stream bundle of the sync transmitter
// Purpose: groups burst request (start/inj_err/inj_pos) and transmitter outputs.
// Ports (master = requester/observer, slave = sync_tx):
//   start, inj_err, inj_pos : master -> slave
//   k, j, en, busy, done    : slave -> master
interface sync_tx_if
  import sync_tx_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             inj_err;
  logic [CNT_W-1:0] inj_pos;
  logic             k;
  logic             j;
  logic             en;
  logic             busy;
  logic             done;

  modport master (
    output start, inj_err, inj_pos,
    input  k, j, en, busy, done
  );

  modport slave (
    input  start, inj_err, inj_pos,
    output k, j, en, busy, done
  );

endinterface

// File: rtl/sync_pattern_gen.sv
// rtl/sync_pattern_gen.sv - combinational K/J sync symbol generator
// Purpose: maps a burst symbol index and an invert flag to a one-hot {k,j} code.
//   Nominal symbol is K on even indices and on the final index, J otherwise.
// Ports:
//   idx_i  in  CNT_W  symbol index within the burst
//   inv_i  in  1      swap K<->J for this symbol (error injection)
//   sym_o  out 2      {k,j}
module sync_pattern_gen
  import sync_tx_pkg::*;
#(
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] idx_i,
  input  logic             inv_i,
  output logic [1:0]       sym_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYNC_LEN - 1);

  logic is_last;
  logic k_nom;

  assign is_last = (idx_i == LAST_IDX);
  // Alternating K,J... with the final pair forced to K,K
  assign k_nom   = ~idx_i[0] | is_last;
  assign sym_o   = (k_nom ^ inv_i) ? SYM_K : SYM_J;

endmodule

// File: rtl/sync_tx.sv
// rtl/sync_tx.sv - K/J sync burst transmitter with single-symbol error injection
// Purpose: on each accepted start emits SYNC_LEN sync symbols, GAP_LEN idle-J
//   cycles with en=1, then a one-cycle done pulse; all outputs registered.
// Ports:
//   clk_i   in  1  clock, rising edge
//   rst_ni  in  1  asynchronous active-low reset
//   bus     sync_tx_if.slave  start/inj_err/inj_pos in, k/j/en/busy/done out
module sync_tx
  import sync_tx_pkg::*;
#(
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int GAP_LEN  = DEF_GAP_LEN,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  sync_tx_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_LEN - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inj_err_q;
  logic [CNT_W-1:0] inj_pos_q;
  logic             k_q, j_q, en_q, busy_q, done_q;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] sym_idx_d;
  logic             sym_inv_d;
  logic [1:0]       sym_d;

  // Outputs are registered, so the symbol loaded at an edge is the one for the
  // index that becomes current after that edge. From IDLE that is index 0 and
  // the injection request is taken straight from the bus (it is latched at the
  // same edge).
  always_comb begin
    cnt_inc   = cnt_q + 1'b1;
    sym_idx_d = '0;
    sym_inv_d = 1'b0;
    if (state_q == ST_IDLE) begin
      sym_idx_d = '0;
      sym_inv_d = bus.inj_err && (bus.inj_pos == '0);
    end else begin
      sym_idx_d = cnt_inc;
      sym_inv_d = inj_err_q && (inj_pos_q == cnt_inc);
    end
  end

  sync_pattern_gen #(
    .SYNC_LEN (SYNC_LEN),
    .CNT_W    (CNT_W)
  ) u_pattern (
    .idx_i (sym_idx_d),
    .inv_i (sym_inv_d),
    .sym_o (sym_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      inj_err_q <= 1'b0;
      inj_pos_q <= '0;
      k_q       <= 1'b0;
      j_q       <= 1'b1;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q      <= ST_SYNC;
            cnt_q        <= '0;
            inj_err_q    <= bus.inj_err;
            inj_pos_q    <= bus.inj_pos;
            {k_q, j_q}   <= sym_d;
            en_q         <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (cnt_q == LAST_SYM) begin
            state_q    <= ST_GAP;
            cnt_q      <= '0;
            {k_q, j_q} <= SYM_J;
          end else begin
            cnt_q      <= cnt_inc;
            {k_q, j_q} <= sym_d;
          end
        end
        ST_GAP: begin
          if (cnt_q == LAST_GAP) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          inj_err_q <= 1'b0;
        end
        default: begin
          // Unreachable encodings fall back to the idle line state
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          inj_err_q  <= 1'b0;
          {k_q, j_q} <= SYM_J;
          en_q       <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.k    = k_q;
  assign bus.j    = j_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
